multi_key_event_decoder: RTL and testbench
==========================================

// Module: multi_key_event_decoder
// PURPOSE
//  Parametrised successor to the single-key toggle decoder. Watches the keyboard
//  scan-code stream (keyCode/make/brakee) for NUM_KEYS run-time programmable codes.
//  Per key it produces: pressed level, press/release pulses, a toggle, and long-press
//  detection. Also provides aggregate status. Sits between the keyboard interface
//  and game/control logic, replacing per-key decoder instances.
// PARAMETERS
//  NUM_KEYS      4      number of independently decoded keys (1..16)
//  CODE_W        9      scan-code width
//  HOLD_CYCLES   50     cycles a key must stay pressed before long-press (>=2)
//  REPEAT_PERIOD 25     cycles between auto-repeat pulses (>=1; KEY_REPEAT_EN only)
// PORTS
//  clk                 in   1                 system clock
//  resetN              in   1                 async reset, active-low
//  keyCode             in   CODE_W            scan code, valid when make or brakee=1
//  make                in   1                 one-cycle strobe: key press
//  brakee              in   1                 one-cycle strobe: key release
//  keyTable            in   NUM_KEYS*CODE_W   code of key i at [i*CODE_W +: CODE_W]
//  clearToggles        in   1                 sync clear of all keyToggle bits
//  keyIsPressed        out  NUM_KEYS          level, key held
//  keyRisingEdgePulse  out  NUM_KEYS          one-cycle pulse on press
//  keyFallingEdgePulse out  NUM_KEYS          one-cycle pulse on release
//  keyToggle           out  NUM_KEYS          flips on every press
//  keyLongPress        out  NUM_KEYS          one-cycle pulse when hold reaches HOLD_CYCLES
//  keyLongHeld         out  NUM_KEYS          level, held past HOLD_CYCLES
//  keyRepeatPulse      out  NUM_KEYS          auto-repeat pulse (0 without KEY_REPEAT_EN)
//  anyKeyPressed       out  1                 OR of keyIsPressed
//  pressedCount        out  $clog2(NUM_KEYS+1) number of keys currently pressed
// BEHAVIOUR
//  - Reset: every output 0, all key FSMs in IDLE, all counters 0.
//  - Per-key FSM: IDLE -> PRESSED -> LONG. Key i matches when keyCode==keyTable[i].
//    IDLE->PRESSED on make&match. PRESSED/LONG->IDLE on brakee&match.
//    PRESSED->LONG when the hold counter reaches HOLD_CYCLES-1.
//  - Timing: make sampled at edge T -> keyIsPressed=1, keyRisingEdgePulse=1 and
//    keyToggle flipped, all at T+1. keyRisingEdgePulse clears at T+2.
//    Release is symmetric: keyIsPressed=0 and keyFallingEdgePulse=1 at T+1.
//  - All outputs are registered. anyKeyPressed and pressedCount are derived
//    combinationally from registered keyIsPressed, so they have the same latency.
//  - make and brakee in the same cycle with a match: brakee wins. If the key was
//    pressed, it releases; if it was idle, nothing happens.
//  - make on an already-pressed key (typematic resend): ignored. No pulse, no toggle
//    flip, and the hold counter is not restarted.
//  - brakee on an idle key: ignored.
//  - Hold counter:
//    - Clears on entering PRESSED, then counts each cycle.
//    - At count HOLD_CYCLES-1 the FSM enters LONG, keyLongPress pulses for 1 cycle
//      and keyLongHeld=1 until release. keyLongPress is therefore asserted HOLD_CYCLES
//      cycles after keyRisingEdgePulse.
//    - Counter width is $clog2(HOLD_CYCLES+1); it saturates and never wraps.
//  - Duplicate codes in keyTable: every matching key reacts independently.
//  - keyTable changes while a key is held: that key stays pressed until a brakee
//    matching the NEW code, or reset.
//  - clearToggles: forces all keyToggle bits to 0. If a rising edge occurs in the same
//    cycle, the clear wins for that key.
//  - Reset asserted mid-hold: immediate return to reset state. No falling pulse is
//    generated on deassertion.
// CONFIGURATION
//  - Macro KEY_REPEAT_EN defined:
//    - Per-key repeat counter of width $clog2(REPEAT_PERIOD+1).
//    - keyRepeatPulse pulses on the keyLongPress cycle, then every REPEAT_PERIOD
//      cycles while in LONG.
//    - The repeat counter resets on leaving LONG.
//  - Macro undefined: no repeat counters are instantiated; keyRepeatPulse is tied to 0.
// TESTING
//  - Reset: hold resetN=0 for 3 cycles -> all outputs 0; release, idle 10 cycles -> still 0.
//  - keyTable={9'h01D,9'h01C,9'h023,9'h029}; make with 9'h029 -> key0 keyIsPressed,
//    rise pulse and toggle=1 at T+1, pressedCount=1; brakee 9'h029 -> key0 fall pulse.
//  - Hold key1 (9'h023) with HOLD_CYCLES=50 -> keyLongPress pulse exactly 50 cycles
//    after the rise pulse, keyLongHeld=1. Release after 49 cycles -> no long press.
//  - make+brakee same cycle on idle key -> no change.
//    Repeated make on a held key -> toggle flips only once.
//  - Press all 4 keys, then clearToggles together with a new press on key2 ->
//    toggles=0, pressedCount=4, anyKeyPressed=1.
//  - KEY_REPEAT_EN with REPEAT_PERIOD=25: hold 110 cycles -> repeat pulses at
//    hold cycles 50, 75 and 100. Repeat with the macro off -> keyRepeatPulse stays 0.

Source files
------------

// File: rtl/multi_key_event_decoder_if.sv
// Keyboard scan-code bus into the multi-key decoder, plus its per-key event outputs.
// master drives scan codes and the key table; slave is the decoder.
interface multi_key_event_decoder_if #(
  parameter int NUM_KEYS = 4,
  parameter int CODE_W   = 9
);
  localparam int CNT_W = $clog2(NUM_KEYS + 1);

  logic [CODE_W-1:0]          keyCode_i;
  logic                       make_i;
  logic                       brakee_i;
  logic [NUM_KEYS*CODE_W-1:0] keyTable_i;
  logic                       clearToggles_i;

  logic [NUM_KEYS-1:0]        keyIsPressed_o;
  logic [NUM_KEYS-1:0]        keyRisingEdgePulse_o;
  logic [NUM_KEYS-1:0]        keyFallingEdgePulse_o;
  logic [NUM_KEYS-1:0]        keyToggle_o;
  logic [NUM_KEYS-1:0]        keyLongPress_o;
  logic [NUM_KEYS-1:0]        keyLongHeld_o;
  logic [NUM_KEYS-1:0]        keyRepeatPulse_o;
  logic                       anyKeyPressed_o;
  logic [CNT_W-1:0]           pressedCount_o;

  modport master (
    output keyCode_i, make_i, brakee_i, keyTable_i, clearToggles_i,
    input  keyIsPressed_o, keyRisingEdgePulse_o, keyFallingEdgePulse_o, keyToggle_o,
           keyLongPress_o, keyLongHeld_o, keyRepeatPulse_o, anyKeyPressed_o, pressedCount_o
  );

  modport slave (
    input  keyCode_i, make_i, brakee_i, keyTable_i, clearToggles_i,
    output keyIsPressed_o, keyRisingEdgePulse_o, keyFallingEdgePulse_o, keyToggle_o,
           keyLongPress_o, keyLongHeld_o, keyRepeatPulse_o, anyKeyPressed_o, pressedCount_o
  );
endinterface

// File: rtl/multi_key_event_decoder.sv
// Decodes NUM_KEYS programmable scan codes into press/release/toggle/long-press events.
// Optional auto-repeat pulses are enabled by defining the macro KEY_REPEAT_EN.
module multi_key_event_decoder #(
  parameter int NUM_KEYS      = 4,
  parameter int CODE_W        = 9,
  parameter int HOLD_CYCLES   = 50,
  parameter int REPEAT_PERIOD = 25
) (
  input  logic                      clk,
  input  logic                      resetN,
  multi_key_event_decoder_if.slave  kbd
);
  localparam int CNT_W = $clog2(NUM_KEYS + 1);
  localparam int HW    = $clog2(HOLD_CYCLES + 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_MAX  = HW'(HOLD_CYCLES);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_PRESSED = 2'd1;
  localparam logic [1:0] ST_LONG    = 2'd2;

`ifdef KEY_REPEAT_EN
  localparam int RW = $clog2(REPEAT_PERIOD + 1);
  localparam logic [RW-1:0] RPT_LAST = RW'(REPEAT_PERIOD - 1);
`endif

  logic [NUM_KEYS-1:0] pressed_vec;
  logic [NUM_KEYS-1:0] rise_vec;
  logic [NUM_KEYS-1:0] fall_vec;
  logic [NUM_KEYS-1:0] tog_vec;
  logic [NUM_KEYS-1:0] lp_vec;
  logic [NUM_KEYS-1:0] held_vec;
  logic [NUM_KEYS-1:0] rpt_vec;
  logic [CNT_W-1:0]    count_sum;

  for (genvar gi = 0; gi < NUM_KEYS; gi++) begin : g_key
    logic [1:0]    state_q, state_d;
    logic [HW-1:0] hold_q, hold_d;
    logic          rise_q, rise_d;
    logic          fall_q, fall_d;
    logic          tog_q, tog_d;
    logic          lp_q, lp_d;
    logic          match, rel, prs;

    always_comb begin
      match   = (kbd.keyCode_i == kbd.keyTable_i[gi*CODE_W +: CODE_W]);
      // brakee has priority; make only acts on an idle key so resends never retrigger
      rel     = kbd.brakee_i && match && (state_q != ST_IDLE);
      prs     = kbd.make_i && !kbd.brakee_i && match && (state_q == ST_IDLE);
      state_d = state_q;
      hold_d  = hold_q;
      rise_d  = 1'b0;
      fall_d  = 1'b0;
      lp_d    = 1'b0;
      tog_d   = tog_q;
      if ((state_q != ST_IDLE) && (hold_q != HOLD_MAX)) begin
        hold_d = hold_q + 1'b1;
      end
      if (rel) begin
        state_d = ST_IDLE;
        fall_d  = 1'b1;
        hold_d  = '0;
      end else if (prs) begin
        state_d = ST_PRESSED;
        rise_d  = 1'b1;
        hold_d  = '0;
        tog_d   = ~tog_q;
      end else if ((state_q == ST_PRESSED) && (hold_q == HOLD_LAST)) begin
        state_d = ST_LONG;
        lp_d    = 1'b1;
      end
      if (kbd.clearToggles_i) begin
        tog_d = 1'b0;
      end
    end

    always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
        state_q <= ST_IDLE;
        hold_q  <= '0;
        rise_q  <= 1'b0;
        fall_q  <= 1'b0;
        tog_q   <= 1'b0;
        lp_q    <= 1'b0;
      end else begin
        state_q <= state_d;
        hold_q  <= hold_d;
        rise_q  <= rise_d;
        fall_q  <= fall_d;
        tog_q   <= tog_d;
        lp_q    <= lp_d;
      end
    end

    assign pressed_vec[gi] = (state_q != ST_IDLE);
    assign held_vec[gi]    = (state_q == ST_LONG);
    assign rise_vec[gi]    = rise_q;
    assign fall_vec[gi]    = fall_q;
    assign tog_vec[gi]     = tog_q;
    assign lp_vec[gi]      = lp_q;

`ifdef KEY_REPEAT_EN
    logic [RW-1:0] rpt_q;
    logic          rpt_pulse_q;

    always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
        rpt_q       <= '0;
        rpt_pulse_q <= 1'b0;
      end else if (lp_d) begin
        rpt_q       <= '0;
        rpt_pulse_q <= 1'b1;
      end else if ((state_q == ST_LONG) && (state_d == ST_LONG)) begin
        if (rpt_q == RPT_LAST) begin
          rpt_q       <= '0;
          rpt_pulse_q <= 1'b1;
        end else begin
          rpt_q       <= rpt_q + 1'b1;
          rpt_pulse_q <= 1'b0;
        end
      end else begin
        rpt_q       <= '0;
        rpt_pulse_q <= 1'b0;
      end
    end

    assign rpt_vec[gi] = rpt_pulse_q;
`else
    assign rpt_vec[gi] = 1'b0;
`endif
  end

  always_comb begin
    count_sum = '0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      count_sum = count_sum + CNT_W'(pressed_vec[i]);
    end
  end

  assign kbd.keyIsPressed_o        = pressed_vec;
  assign kbd.keyRisingEdgePulse_o  = rise_vec;
  assign kbd.keyFallingEdgePulse_o = fall_vec;
  assign kbd.keyToggle_o           = tog_vec;
  assign kbd.keyLongPress_o        = lp_vec;
  assign kbd.keyLongHeld_o         = held_vec;
  assign kbd.keyRepeatPulse_o      = rpt_vec;
  assign kbd.anyKeyPressed_o       = |pressed_vec;
  assign kbd.pressedCount_o        = count_sum;
endmodule

// File: tb/tb_multi_key_event_decoder.sv
// Directed bench for multi_key_event_decoder (4 keys, HOLD_CYCLES=50, REPEAT_PERIOD=25).
// Inputs change on the falling edge; outputs are read on the falling edge after the strobe.
module tb_multi_key_event_decoder;
  logic clk;
  logic resetN;
  int   total;
  int   bad;

  localparam logic [35:0] TABLE0 = {9'h01D, 9'h01C, 9'h023, 9'h029};

  multi_key_event_decoder_if #(.NUM_KEYS(4), .CODE_W(9)) kbd ();

  multi_key_event_decoder #(
    .NUM_KEYS(4), .CODE_W(9), .HOLD_CYCLES(50), .REPEAT_PERIOD(25)
  ) dut (
    .clk    (clk),
    .resetN (resetN),
    .kbd    (kbd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Called at a falling edge; the strobe is sampled by the next rising edge.
  task automatic send(input logic [8:0] code, input logic mk, input logic br);
    kbd.keyCode_i = code;
    kbd.make_i    = mk;
    kbd.brakee_i  = br;
    @(negedge clk);
    kbd.make_i    = 1'b0;
    kbd.brakee_i  = 1'b0;
    $display("txn code=%h make=%0d brakee=%0d pressed=%b rise=%b fall=%b tog=%b cnt=%0d",
             code, mk, br, kbd.keyIsPressed_o, kbd.keyRisingEdgePulse_o,
             kbd.keyFallingEdgePulse_o, kbd.keyToggle_o, kbd.pressedCount_o);
  endtask

  task automatic test_reset();
    logic [31:0] all_out;
    resetN             = 1'b0;
    kbd.keyCode_i      = '0;
    kbd.make_i         = 1'b0;
    kbd.brakee_i       = 1'b0;
    kbd.clearToggles_i = 1'b0;
    kbd.keyTable_i     = TABLE0;
    repeat (3) @(negedge clk);
    all_out = {kbd.keyIsPressed_o, kbd.keyRisingEdgePulse_o, kbd.keyFallingEdgePulse_o,
               kbd.keyToggle_o, kbd.keyLongPress_o, kbd.keyLongHeld_o, kbd.keyRepeatPulse_o,
               kbd.anyKeyPressed_o, kbd.pressedCount_o};
    total++;
    if (all_out !== 32'h0) begin bad++; $display("FAIL reset_outputs got=%h exp=0", all_out); end
    resetN = 1'b1;
    repeat (10) @(negedge clk);
    all_out = {kbd.keyIsPressed_o, kbd.keyRisingEdgePulse_o, kbd.keyFallingEdgePulse_o,
               kbd.keyToggle_o, kbd.keyLongPress_o, kbd.keyLongHeld_o, kbd.keyRepeatPulse_o,
               kbd.anyKeyPressed_o, kbd.pressedCount_o};
    total++;
    if (all_out !== 32'h0) begin bad++; $display("FAIL idle_after_reset got=%h exp=0", all_out); end
  endtask

  task automatic test_press_release();
    send(9'h029, 1'b1, 1'b0);
    total++;
    if (kbd.keyIsPressed_o !== 4'b0001) begin bad++; $display("FAIL press_level got=%b exp=0001", kbd.keyIsPressed_o); end
    total++;
    if (kbd.keyRisingEdgePulse_o !== 4'b0001) begin bad++; $display("FAIL press_rise got=%b exp=0001", kbd.keyRisingEdgePulse_o); end
    total++;
    if (kbd.keyToggle_o !== 4'b0001) begin bad++; $display("FAIL press_toggle got=%b exp=0001", kbd.keyToggle_o); end
    total++;
    if ({kbd.anyKeyPressed_o, kbd.pressedCount_o} !== {1'b1, 3'd1}) begin
      bad++; $display("FAIL press_count got=%b/%0d exp=1/1", kbd.anyKeyPressed_o, kbd.pressedCount_o);
    end
    @(negedge clk);
    total++;
    if (kbd.keyRisingEdgePulse_o !== 4'b0000) begin bad++; $display("FAIL rise_one_cycle got=%b exp=0000", kbd.keyRisingEdgePulse_o); end
    send(9'h029, 1'b0, 1'b1);
    total++;
    if ({kbd.keyIsPressed_o, kbd.keyFallingEdgePulse_o} !== 8'b0000_0001) begin
      bad++; $display("FAIL release got=%b/%b exp=0000/0001", kbd.keyIsPressed_o, kbd.keyFallingEdgePulse_o);
    end
    @(negedge clk);
    total++;
    if ({kbd.keyFallingEdgePulse_o, kbd.keyToggle_o} !== 8'b0000_0001) begin
      bad++; $display("FAIL fall_one_cycle got=%b/%b exp=0000/0001", kbd.keyFallingEdgePulse_o, kbd.keyToggle_o);
    end
  endtask

  task automatic test_long_press();
    int early;
    logic [127:0] rpt_seen;
    logic [127:0] rpt_exp;
    early    = 0;
    rpt_seen = '0;
    rpt_exp  = '0;
`ifdef KEY_REPEAT_EN
    rpt_exp[50]  = 1'b1;
    rpt_exp[75]  = 1'b1;
    rpt_exp[100] = 1'b1;
`endif
    send(9'h023, 1'b1, 1'b0);
    total++;
    if (kbd.keyRisingEdgePulse_o !== 4'b0010) begin bad++; $display("FAIL long_rise got=%b exp=0010", kbd.keyRisingEdgePulse_o); end
    for (int k = 1; k <= 110; k++) begin
      @(negedge clk);
      if (k < 50 && (kbd.keyLongPress_o[1] || kbd.keyLongHeld_o[1])) early++;
      if (kbd.keyRepeatPulse_o[1]) rpt_seen[k] = 1'b1;
      if (k == 50) begin
        total++;
        if ({kbd.keyLongPress_o, kbd.keyLongHeld_o} !== 8'b0010_0010) begin
          bad++; $display("FAIL long_at_50 got=%b/%b exp=0010/0010", kbd.keyLongPress_o, kbd.keyLongHeld_o);
        end
      end
      if (k == 51) begin
        total++;
        if ({kbd.keyLongPress_o, kbd.keyLongHeld_o} !== 8'b0000_0010) begin
          bad++; $display("FAIL long_after got=%b/%b exp=0000/0010", kbd.keyLongPress_o, kbd.keyLongHeld_o);
        end
      end
    end
    total++;
    if (early !== 0) begin bad++; $display("FAIL long_early got=%0d exp=0", early); end
    total++;
    if (rpt_seen !== rpt_exp) begin bad++; $display("FAIL repeat_cycles got=%h exp=%h", rpt_seen, rpt_exp); end
    send(9'h023, 1'b0, 1'b1);
    total++;
    if ({kbd.keyLongHeld_o, kbd.keyFallingEdgePulse_o, kbd.keyIsPressed_o} !== 12'b0000_0010_0000) begin
      bad++; $display("FAIL long_release got=%b/%b/%b exp=0000/0010/0000",
                      kbd.keyLongHeld_o, kbd.keyFallingEdgePulse_o, kbd.keyIsPressed_o);
    end
  endtask

  task automatic test_short_hold();
    int seen;
    seen = 0;
    send(9'h023, 1'b1, 1'b0);
    repeat (48) begin
      @(negedge clk);
      if (kbd.keyLongPress_o[1] || kbd.keyLongHeld_o[1]) seen++;
    end
    send(9'h023, 1'b0, 1'b1);
    total++;
    if (kbd.keyIsPressed_o !== 4'b0000) begin bad++; $display("FAIL short_release got=%b exp=0000", kbd.keyIsPressed_o); end
    repeat (5) begin
      @(negedge clk);
      if (kbd.keyLongPress_o[1] || kbd.keyLongHeld_o[1]) seen++;
    end
    total++;
    if (seen !== 0) begin bad++; $display("FAIL short_no_long got=%0d exp=0", seen); end
  endtask

  task automatic test_same_cycle_and_resend();
    send(9'h01C, 1'b1, 1'b1);
    total++;
    if ({kbd.keyIsPressed_o, kbd.keyRisingEdgePulse_o, kbd.keyToggle_o} !== 12'b0000_0000_0001) begin
      bad++; $display("FAIL make_brakee_idle got=%b/%b/%b exp=0000/0000/0001",
                      kbd.keyIsPressed_o, kbd.keyRisingEdgePulse_o, kbd.keyToggle_o);
    end
    send(9'h01C, 1'b1, 1'b0);
    send(9'h01C, 1'b1, 1'b0);
    total++;
    if ({kbd.keyRisingEdgePulse_o, kbd.keyToggle_o, kbd.pressedCount_o} !== {4'b0000, 4'b0101, 3'd1}) begin
      bad++; $display("FAIL resend_ignored got=%b/%b/%0d exp=0000/0101/1",
                      kbd.keyRisingEdgePulse_o, kbd.keyToggle_o, kbd.pressedCount_o);
    end
    send(9'h01C, 1'b1, 1'b1);
    total++;
    if ({kbd.keyIsPressed_o, kbd.keyFallingEdgePulse_o} !== 8'b0000_0100) begin
      bad++; $display("FAIL make_brakee_held got=%b/%b exp=0000/0100", kbd.keyIsPressed_o, kbd.keyFallingEdgePulse_o);
    end
  endtask

  task automatic test_clear_toggles();
    send(9'h029, 1'b1, 1'b0);
    send(9'h023, 1'b1, 1'b0);
    send(9'h01D, 1'b1, 1'b0);
    total++;
    if (kbd.keyToggle_o !== 4'b1110) begin bad++; $display("FAIL toggles_before_clear got=%b exp=1110", kbd.keyToggle_o); end
    kbd.clearToggles_i = 1'b1;
    send(9'h01C, 1'b1, 1'b0);
    kbd.clearToggles_i = 1'b0;
    total++;
    if ({kbd.keyToggle_o, kbd.keyRisingEdgePulse_o, kbd.keyIsPressed_o} !== 12'b0000_0100_1111) begin
      bad++; $display("FAIL clear_toggles got=%b/%b/%b exp=0000/0100/1111",
                      kbd.keyToggle_o, kbd.keyRisingEdgePulse_o, kbd.keyIsPressed_o);
    end
    total++;
    if ({kbd.anyKeyPressed_o, kbd.pressedCount_o} !== {1'b1, 3'd4}) begin
      bad++; $display("FAIL all_pressed got=%b/%0d exp=1/4", kbd.anyKeyPressed_o, kbd.pressedCount_o);
    end
  endtask

  task automatic test_reset_mid_hold();
    int falls;
    falls = 0;
    resetN = 1'b0;
    #1;
    total++;
    if ({kbd.keyIsPressed_o, kbd.pressedCount_o, kbd.anyKeyPressed_o} !== 8'h00) begin
      bad++; $display("FAIL async_reset got=%b/%0d exp=0000/0", kbd.keyIsPressed_o, kbd.pressedCount_o);
    end
    repeat (2) @(negedge clk);
    resetN = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (kbd.keyFallingEdgePulse_o !== 4'b0000 || kbd.keyIsPressed_o !== 4'b0000) falls++;
    end
    total++;
    if (falls !== 0) begin bad++; $display("FAIL no_fall_after_reset got=%0d exp=0", falls); end
  endtask

  task automatic test_duplicate_and_remap();
    kbd.keyTable_i = {9'h029, 9'h01C, 9'h023, 9'h029};
    send(9'h029, 1'b1, 1'b0);
    total++;
    if ({kbd.keyIsPressed_o, kbd.pressedCount_o} !== {4'b1001, 3'd2}) begin
      bad++; $display("FAIL duplicate_press got=%b/%0d exp=1001/2", kbd.keyIsPressed_o, kbd.pressedCount_o);
    end
    send(9'h029, 1'b0, 1'b1);
    total++;
    if ({kbd.keyIsPressed_o, kbd.keyFallingEdgePulse_o} !== 8'b0000_1001) begin
      bad++; $display("FAIL duplicate_release got=%b/%b exp=0000/1001", kbd.keyIsPressed_o, kbd.keyFallingEdgePulse_o);
    end
    kbd.keyTable_i = TABLE0;
    send(9'h023, 1'b1, 1'b0);
    kbd.keyTable_i = {9'h01D, 9'h01C, 9'h055, 9'h029};
    send(9'h023, 1'b0, 1'b1);
    total++;
    if ({kbd.keyIsPressed_o, kbd.keyFallingEdgePulse_o} !== 8'b0010_0000) begin
      bad++; $display("FAIL remap_old_code got=%b/%b exp=0010/0000", kbd.keyIsPressed_o, kbd.keyFallingEdgePulse_o);
    end
    send(9'h055, 1'b0, 1'b1);
    total++;
    if ({kbd.keyIsPressed_o, kbd.keyFallingEdgePulse_o} !== 8'b0000_0010) begin
      bad++; $display("FAIL remap_new_code got=%b/%b exp=0000/0010", kbd.keyIsPressed_o, kbd.keyFallingEdgePulse_o);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_press_release();
    test_long_press();
    test_short_hold();
    test_same_cycle_and_resend();
    test_clear_toggles();
    test_reset_mid_hold();
    test_duplicate_and_remap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
